// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter.
//   state_e     : sequencer states (idle, execute, respond)
//   OPC_W       : opcode width
//   OPC_ILLEGAL : the one opcode the ALU does not implement
//   OPC_MAX     : highest legal opcode
package alu_arb_pkg;

  localparam int unsigned OPC_W = 3;
  localparam logic [OPC_W-1:0] OPC_ILLEGAL = 3'd7;
  localparam logic [OPC_W-1:0] OPC_MAX = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/ALU1.sv
// Single-cycle combinational ALU shared by the arbiter.
// Ports:
//   opc  : operation select (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not M, 6 shift-left M with carry-in)
//   inM  : first operand
//   inN  : second operand
//   inC  : carry-in (add, shift-left)
//   outF : W-bit result, no width extension
//   zer  : result is zero
//   neg  : result MSB
module ALU1 #(
  parameter int unsigned W = 16
) (
  input  logic [2:0]   opc,
  input  logic [W-1:0] inM,
  input  logic [W-1:0] inN,
  input  logic         inC,
  output logic [W-1:0] outF,
  output logic         zer,
  output logic         neg
);

  always_comb begin
    outF = '0;
    case (opc)
      3'd0:    outF = inM + inN + {{(W-1){1'b0}}, inC};
      3'd1:    outF = inM - inN;
      3'd2:    outF = inM & inN;
      3'd3:    outF = inM | inN;
      3'd4:    outF = inM ^ inN;
      3'd5:    outF = ~inM;
      3'd6:    outF = {inM[W-2:0], inC};
      default: outF = '0;
    endcase
  end

  assign zer = (outF == '0);
  assign neg = outF[W-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU1 between NREQ requesters.
// One operation in flight: grant in IDLE, run the latched operands through the ALU in EXEC,
// hold the registered result in RESP until the consumer accepts it.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester request handshake (at most one ready bit high)
//   req_opc/inM/inN/inC : per-requester operation and operands
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : index of the requester owning the response
//   rsp_outF/zer/neg    : registered ALU result and flags (forced to 0 for an illegal opcode)
//   rsp_err             : latched opcode was illegal
//   busy                : sequencer is not idle
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][OPC_W-1:0] req_opc,
  input  logic [NREQ-1:0][W-1:0]     req_inM,
  input  logic [NREQ-1:0][W-1:0]     req_inN,
  input  logic [NREQ-1:0]            req_inC,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [W-1:0]               rsp_outF,
  output logic                       rsp_zer,
  output logic                       rsp_neg,
  output logic                       rsp_err,
  output logic                       busy
);

  state_e state_q, state_d;

  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   g_q;
  logic [OPC_W-1:0] opc_q;
  logic [W-1:0]     inm_q, inn_q;
  logic             inc_q;

  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [W-1:0]     rsp_outf_q;
  logic             rsp_zer_q, rsp_neg_q, rsp_err_q;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic             take, capture, complete;

  logic [W-1:0]     alu_f;
  logic             alu_zer, alu_neg;
  logic             opc_bad;

  // First valid requester at or after ptr, searching modulo NREQ.
  always_comb begin
    logic [IDW-1:0] j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = IDW'((32'(ptr_q) + 32'(i)) % NREQ);
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = j;
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    take      = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gated by rst so no grant is advertised while reset is asserted.
        if (gnt_found && rst) begin
          req_ready[gnt_idx] = 1'b1;
          take               = 1'b1;
          state_d            = StExec;
        end
      end
      StExec: begin
        capture = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // The ALU only ever sees the latched operands.
  ALU1 #(
    .W(W)
  ) u_alu (
    .opc  (opc_q),
    .inM  (inm_q),
    .inN  (inn_q),
    .inC  (inc_q),
    .outF (alu_f),
    .zer  (alu_zer),
    .neg  (alu_neg)
  );

  assign opc_bad = (opc_q > OPC_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      g_q         <= '0;
      opc_q       <= '0;
      inm_q       <= '0;
      inn_q       <= '0;
      inc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_outf_q  <= '0;
      rsp_zer_q   <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (take) begin
        g_q   <= gnt_idx;
        opc_q <= req_opc[gnt_idx];
        inm_q <= req_inM[gnt_idx];
        inn_q <= req_inN[gnt_idx];
        inc_q <= req_inC[gnt_idx];
      end
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= g_q;
        rsp_err_q   <= opc_bad;
        rsp_outf_q  <= opc_bad ? '0 : alu_f;
        rsp_zer_q   <= opc_bad ? 1'b0 : alu_zer;
        rsp_neg_q   <= opc_bad ? 1'b0 : alu_neg;
      end
      if (complete) begin
        rsp_valid_q <= 1'b0;
        // Pointer moves only when a response retires, one past its owner.
        ptr_q       <= IDW'((32'(g_q) + 32'd1) % NREQ);
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_outF  = rsp_outf_q;
  assign rsp_zer   = rsp_zer_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);

  // Illegal opcode value is documented here so both definitions stay in step.
  if (OPC_ILLEGAL != OPC_MAX + 3'd1) begin : g_opc_check
    $error("OPC_ILLEGAL must be one past OPC_MAX");
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table vectors, hand-written corner sequences and
// randomized traffic checked against a behavioural model of grant order and ALU results.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned W    = 16;
  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [NREQ-1:0]            req_valid = '0;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][OPC_W-1:0] req_opc = '0;
  logic [NREQ-1:0][W-1:0]     req_inM = '0;
  logic [NREQ-1:0][W-1:0]     req_inN = '0;
  logic [NREQ-1:0]            req_inC = '0;
  logic                       rsp_valid;
  logic                       rsp_ready = 1'b0;
  logic [IDW-1:0]             rsp_id;
  logic [W-1:0]               rsp_outF;
  logic                       rsp_zer, rsp_neg, rsp_err, busy;

  alu_arbiter #(
    .W    (W),
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opc   (req_opc),
    .req_inM   (req_inM),
    .req_inN   (req_inN),
    .req_inC   (req_inC),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_outF  (rsp_outF),
    .rsp_zer   (rsp_zer),
    .rsp_neg   (rsp_neg),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] f;
    logic         zer;
    logic         neg;
    logic         err;
  } res_t;

  typedef struct {
    int           req;
    logic [2:0]   opc;
    logic [W-1:0] m;
    logic [W-1:0] n;
    logic         c;
    logic [W-1:0] f;
    logic         zer;
    logic         neg;
    logic         err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int ptr_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU behaviour from plain integer arithmetic, truncated to W bits.
  function automatic res_t alu_ref(input logic [2:0] op, input logic [W-1:0] m,
                                   input logic [W-1:0] n, input logic c);
    res_t r;
    int unsigned a, b, f;
    a = m;
    b = n;
    case (op)
      3'd0:    f = a + b + c;
      3'd1:    f = a + 65536 - b;
      3'd2:    f = a & b;
      3'd3:    f = a | b;
      3'd4:    f = a ^ b;
      3'd5:    f = 65535 - a;
      3'd6:    f = a * 2 + c;
      default: f = 0;
    endcase
    r.err = (op == 3'd7);
    r.f   = r.err ? '0 : f[W-1:0];
    r.zer = !r.err && (r.f == '0);
    r.neg = !r.err && r.f[W-1];
    return r;
  endfunction

  function automatic int model_grant();
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[(ptr_m + i) % NREQ]) return (ptr_m + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic rand_req(input int r);
    req_valid[r] = 1'b1;
    req_opc[r]   = 3'($urandom_range(0, 7));
    req_inM[r]   = 16'($urandom);
    req_inN[r]   = 16'($urandom);
    req_inC[r]   = 1'($urandom);
  endtask

  // Entered just after a posedge with state idle and requests driven; returns 2 time units
  // after the edge on which the response retired.
  task automatic txn(input int hold, input bit keep, output res_t got, output int gid);
    int   g;
    res_t e;
    logic [31:0] snap;
    got = '0;
    gid = -1;
    #1;
    g = model_grant();
    if (g < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL txn_no_request: got none expected a valid request");
      return;
    end
    gid = g;
    check("grant", 32'(req_ready), 32'(1) << g);
    check("grant_busy", 32'(busy), 0);
    e = alu_ref(req_opc[g], req_inM[g], req_inN[g], req_inC[g]);
    @(posedge clk);
    #1;
    if (keep) rand_req(g);
    else req_valid[g] = 1'b0;
    rsp_ready = (hold == 0);
    #1;
    check("exec_rsp_valid", 32'(rsp_valid), 0);
    check("exec_busy", 32'(busy), 1);
    check("exec_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #2;
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_id", 32'(rsp_id), 32'(g));
    check("rsp_outF", 32'(rsp_outF), 32'(e.f));
    check("rsp_flags", {29'd0, rsp_zer, rsp_neg, rsp_err}, {29'd0, e.zer, e.neg, e.err});
    check("resp_req_ready", 32'(req_ready), 0);
    got  = '{f: rsp_outF, zer: rsp_zer, neg: rsp_neg, err: rsp_err};
    snap = {12'd0, rsp_id, rsp_outF, rsp_zer, rsp_neg, rsp_err};
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #2;
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_stable", {12'd0, rsp_id, rsp_outF, rsp_zer, rsp_neg, rsp_err}, snap);
      check("hold_busy", 32'(busy), 1);
      check("hold_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    check("done_valid", 32'(rsp_valid), 0);
    check("done_busy", 32'(busy), 0);
    ptr_m = (g + 1) % NREQ;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {20'd0, req_ready, rsp_valid, rsp_id, rsp_zer, rsp_neg, rsp_err, busy}, 0);
    check({name, "_outF"}, 32'(rsp_outF), 0);
  endtask

  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t got;
    int   gid;

    tbl[0]  = '{0, 3'd0, 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{0, 3'd0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1, 3'd1, 16'h0007, 16'h0007, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{0, 3'd1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1, 3'd2, 16'hF0F0, 16'h0F0F, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{0, 3'd2, 16'h8001, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1, 3'd3, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{0, 3'd3, 16'h8000, 16'h0001, 1'b0, 16'h8001, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1, 3'd4, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{0, 3'd4, 16'hFFFF, 16'h7FFF, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1, 3'd5, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{0, 3'd5, 16'h0000, 16'hABCD, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1, 3'd6, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{0, 3'd6, 16'h4000, 16'h0000, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1, 3'd7, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1, 3'd1, 16'h000A, 16'h0003, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{0, 3'd7, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

    // Reset: outputs quiet, no grant advertised even with a request pending.
    req_valid = 2'b01;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset_outputs");
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("post_reset_outputs");

    // Table vectors, one requester at a time, response accepted immediately.
    for (int i = 0; i < 18; i++) begin
      req_valid[tbl[i].req] = 1'b1;
      req_opc[tbl[i].req]   = tbl[i].opc;
      req_inM[tbl[i].req]   = tbl[i].m;
      req_inN[tbl[i].req]   = tbl[i].n;
      req_inC[tbl[i].req]   = tbl[i].c;
      txn(0, 1'b0, got, gid);
      check("tbl_id", 32'(gid), 32'(tbl[i].req));
      check("tbl_result", {12'd0, got.f, got.zer, got.neg, got.err},
            {12'd0, tbl[i].f, tbl[i].zer, tbl[i].neg, tbl[i].err});
    end

    // Back-pressure with both requesters waiting; the next grant follows the release.
    rand_req(0);
    rand_req(1);
    txn(5, 1'b1, got, gid);
    txn(0, 1'b0, got, gid);
    req_valid = '0;

    // Reset while an operation is in EXEC.
    req_valid = 2'b11;
    #1;
    check("rst_exec_grant", 32'(req_ready), 32'(1) << model_grant());
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    #1;
    check_all_zero("rst_exec_outputs");
    @(posedge clk);
    #1;
    rst   = 1'b1;
    ptr_m = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #2;
      check("rst_exec_no_rsp", {30'd0, rsp_valid, busy}, 0);
    end

    // Contention: both continuously valid, grants must alternate from requester 0.
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 6; i++) begin
      txn(0, 1'b1, got, gid);
      check("contention_order", 32'(gid), 32'(i % 2));
    end
    req_valid = '0;

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!req_valid[r] && $urandom_range(0, 1) == 1) rand_req(r);
      end
      if (req_valid == '0) rand_req(int'($urandom_range(0, NREQ - 1)));
      txn(int'($urandom_range(0, 2)), 1'($urandom), got, gid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
